// File: rtl/mine_ind_calc.sv
// mine_ind_calc: Wishbone master that walks the board once and writes each cell's
// neighbour mine count into bits 4:1, preserving all other field bits.
module mine_ind_calc #(
    parameter int ROWS = 16,
    parameter int COLS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] ADR_O,
    output logic [7:0] DAT_O,
    input  logic [7:0] DAT_I,
    output logic       WE_O,
    output logic       STB_O,
    output logic       CYC_O,
    input  logic       ACK_I
);
    localparam logic [2:0] IDLE = 3'd0, RD_CTR = 3'd1, RD_NBR = 3'd2, WR = 3'd3, FIN = 3'd4;
    localparam logic [3:0] RMAX = 4'(ROWS - 1), CMAX = 4'(COLS - 1);

    logic [2:0] state, nidx, nxt;
    logic [3:0] row, col, cnt, lo, nrow, ncol, next_row, next_col;
    logic [7:0] hold, vmask;
    logic       gap, stb, nxt_ok, last;

    assign STB_O = stb;
    assign CYC_O = stb;

    // Neighbour index i is usable when bit i of vmask is set; order is (-1,-1)..(+1,+1).
    always_comb begin
        vmask = {(row != RMAX) && (col != CMAX), row != RMAX, (row != RMAX) && (col != 4'd0),
                 col != CMAX, col != 4'd0,
                 (row != 4'd0) && (col != CMAX), row != 4'd0, (row != 4'd0) && (col != 4'd0)};
        lo = (state == RD_CTR) ? 4'd0 : {1'b0, nidx} + 4'd1;
        nxt = 3'd0;
        nxt_ok = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (vmask[i] && 4'(i) >= lo) begin
                nxt = 3'(i);
                nxt_ok = 1'b1;
            end
        end
        nrow = (nxt < 3'd3) ? row - 4'd1 : (nxt > 3'd4) ? row + 4'd1 : row;
        ncol = (nxt == 3'd0 || nxt == 3'd3 || nxt == 3'd5) ? col - 4'd1 :
               (nxt == 3'd1 || nxt == 3'd6) ? col : col + 4'd1;
        next_row = (col == CMAX) ? row + 4'd1 : row;
        next_col = (col == CMAX) ? 4'd0 : col + 4'd1;
        last = (row == RMAX) && (col == CMAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            row   <= 4'd0;
            col   <= 4'd0;
            cnt   <= 4'd0;
            nidx  <= 3'd0;
            hold  <= 8'h00;
            gap   <= 1'b0;
            stb   <= 1'b0;
            WE_O  <= 1'b0;
            ADR_O <= 8'h00;
            DAT_O <= 8'h00;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    row   <= 4'd0;
                    col   <= 4'd0;
                    ADR_O <= 8'h00;
                    WE_O  <= 1'b0;
                    stb   <= 1'b1;
                    busy  <= 1'b1;
                    state <= RD_CTR;
                end
            end else if (state == FIN) begin
                state <= IDLE;
            end else if (stb && ACK_I) begin
                stb  <= 1'b0;
                gap  <= 1'b1;
                WE_O <= 1'b0;
                if (state == RD_CTR) hold <= DAT_I;
                if (state == RD_NBR) cnt <= cnt + {3'd0, DAT_I[7]};
            end else if (gap) begin
                // The slave's trailing ack lands here and is ignored; all advance decisions happen now.
                gap <= 1'b0;
                if (state == RD_CTR) begin
                    cnt   <= 4'd0;
                    nidx  <= nxt;
                    ADR_O <= {nrow, ncol};
                    stb   <= 1'b1;
                    state <= RD_NBR;
                end else if (state == RD_NBR && nxt_ok) begin
                    nidx  <= nxt;
                    ADR_O <= {nrow, ncol};
                    stb   <= 1'b1;
                end else if (state == RD_NBR) begin
                    WE_O  <= 1'b1;
                    ADR_O <= {row, col};
                    DAT_O <= (hold & 8'hE1) | {3'd0, cnt, 1'b0};
                    stb   <= 1'b1;
                    state <= WR;
                end else if (last) begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= FIN;
                end else begin
                    row   <= next_row;
                    col   <= next_col;
                    ADR_O <= {next_row, next_col};
                    stb   <= 1'b1;
                    state <= RD_CTR;
                end
            end
        end
    end
endmodule

// File: tb/tb_mine_ind_calc.sv
// tb_mine_ind_calc: drives a 2x2 and a 16x16 instance against behavioural memory slaves
// and compares bus order, cycle counts and final boards to a rule-level model.
module tb_mine_ind_calc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start [2];
    logic       busy [2], done [2], we [2], stb [2], cyc [2], ack [2];
    logic [7:0] adr [2], dato [2], dati [2];
    logic [7:0] mem [2][256];
    logic [7:0] orig [256];
    int         wcnt [2];
    int         ws = 0, sel = 0, checks = 0, failures = 0;
    logic [8:0] obs [32768];
    int         obs_n = 0, stbcyc_bad = 0;
    logic [8:0] expq [$];
    logic [7:0] expb [256];

    generate
        for (genvar k = 0; k < 2; k++) begin : g
            mine_ind_calc #(.ROWS(k == 0 ? 2 : 16), .COLS(k == 0 ? 2 : 16)) u_dut (
                .clk(clk), .rst_n(rst_n), .start(start[k]), .busy(busy[k]), .done(done[k]),
                .ADR_O(adr[k]), .DAT_O(dato[k]), .DAT_I(dati[k]), .WE_O(we[k]),
                .STB_O(stb[k]), .CYC_O(cyc[k]), .ACK_I(ack[k]));
            assign dati[k] = mem[k][adr[k]];
        end
    endgenerate

    // Registered slave with ws wait states; ack stays up while STB is seen, giving the trailing ack.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (stb[k] && cyc[k]) begin
                if (wcnt[k] >= ws) begin
                    ack[k] <= 1'b1;
                    if (we[k]) mem[k][adr[k]] = dato[k];
                end else begin
                    wcnt[k] <= wcnt[k] + 1;
                    ack[k] <= 1'b0;
                end
            end else begin
                wcnt[k] <= 0;
                ack[k] <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (stb[sel] !== cyc[sel]) stbcyc_bad <= stbcyc_bad + 1;
            if (stb[sel] && ack[sel]) begin
                obs[15'(obs_n)] <= {we[sel], adr[sel]};
                obs_n <= obs_n + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Expected access list and final board straight from the cell/neighbour rules.
    task automatic build(input int k);
        int n;
        n = (k == 0) ? 2 : 16;
        expq.delete();
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                int m;
                m = 0;
                expq.push_back({1'b0, 4'(r), 4'(c)});
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < n && c + dc >= 0 && c + dc < n) begin
                            expq.push_back({1'b0, 4'(r + dr), 4'(c + dc)});
                            m += int'(mem[k][(r + dr) * 16 + c + dc][7]);
                        end
                    end
                end
                expq.push_back({1'b1, 4'(r), 4'(c)});
                expb[r * 16 + c] = {mem[k][r * 16 + c][7:5], 4'(m), mem[k][r * 16 + c][0]};
            end
        end
    endtask

    task automatic run(input int k, input int w, input bit spam, input string tag, output int cycles, output int nacc);
        int cy, dn, base, bad, n;
        n = (k == 0) ? 2 : 16;
        ws = w;
        sel = k;
        build(k);
        @(negedge clk);
        base = obs_n;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        cy = 1;
        chk({tag, "_busy_up"}, 32'(busy[k]), 32'd1);
        chk({tag, "_stb_up"}, 32'(stb[k]), 32'd1);
        while (!done[k] && cy < 20000) begin
            start[k] = spam && (cy % 5 == 2);
            @(negedge clk);
            cy++;
        end
        start[k] = 1'b0;
        cycles = cy;
        chk({tag, "_cycles"}, 32'(cy), 32'((3 + w) * expq.size() + 1));
        chk({tag, "_busy_at_done"}, 32'(busy[k]), 32'd0);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            dn += int'(done[k]);
        end
        chk({tag, "_extra_done"}, 32'(dn), 32'd0);
        nacc = obs_n - base;
        chk({tag, "_accesses"}, 32'(nacc), 32'(expq.size()));
        bad = 0;
        for (int i = 0; i < expq.size(); i++) if (obs[15'(base + i)] !== expq[i]) bad++;
        chk({tag, "_bus_order"}, 32'(bad), 32'd0);
        bad = 0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                if (mem[k][r * 16 + c] !== expb[r * 16 + c]) bad++;
        chk({tag, "_board"}, 32'(bad), 32'd0);
    endtask

    task automatic load_small();
        mem[0][8'h00] = 8'h80;
        mem[0][8'h01] = 8'h40;
        mem[0][8'h10] = 8'h40;
        mem[0][8'h11] = 8'h40;
    endtask

    task automatic check_small(input string tag);
        chk({tag, "_c00"}, 32'(mem[0][8'h00]), 32'h80);
        chk({tag, "_c01"}, 32'(mem[0][8'h01]), 32'h42);
        chk({tag, "_c10"}, 32'(mem[0][8'h10]), 32'h42);
        chk({tag, "_c11"}, 32'(mem[0][8'h11]), 32'h42);
    endtask

    initial begin
        int cy, na, bad, e, dn, act;
        logic [7:0] want;
        start[0] = 1'b0;
        start[1] = 1'b0;
        for (int a = 0; a < 256; a++) begin
            mem[0][a] = 8'h00;
            mem[1][a] = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_busy", 32'(busy[k]), 32'd0);
            chk("reset_done", 32'(done[k]), 32'd0);
            chk("reset_stb_cyc_we", 32'({stb[k], cyc[k], we[k]}), 32'd0);
            chk("reset_adr", 32'(adr[k]), 32'd0);
            chk("reset_dat", 32'(dato[k]), 32'd0);
        end
        rst_n = 1'b1;

        load_small();
        run(0, 0, 1'b0, "small", cy, na);
        chk("small_61_cycles", 32'(cy), 32'd61);
        check_small("small");

        load_small();
        run(0, 2, 1'b0, "small_ws2", cy, na);
        chk("small_ws2_101_cycles", 32'(cy), 32'd101);
        check_small("small_ws2");

        for (int a = 0; a < 256; a++) mem[1][a] = 8'h80;
        run(1, 0, 1'b0, "all_mines", cy, na);
        chk("all_mines_7117_cycles", 32'(cy), 32'd7117);
        chk("all_mines_nbr_reads", 32'(na - 512), 32'd1860);
        bad = 0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                e = int'(r == 0 || r == 15) + int'(c == 0 || c == 15);
                want = (e == 2) ? 8'h86 : (e == 1) ? 8'h8A : 8'h90;
                if (mem[1][r * 16 + c] !== want) bad++;
            end
        end
        chk("all_mines_counts", 32'(bad), 32'd0);

        for (int a = 0; a < 256; a++) begin
            mem[1][a] = 8'($urandom) & 8'h61;
            orig[a] = mem[1][a];
        end
        run(1, 0, 1'b0, "empty", cy, na);
        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[1][a] !== orig[a]) bad++;
        chk("empty_unchanged", 32'(bad), 32'd0);

        for (int a = 0; a < 256; a++) mem[1][a] = 8'($urandom);
        run(1, 1, 1'b0, "random_ws1", cy, na);

        load_small();
        run(0, 0, 1'b1, "start_spam", cy, na);
        chk("start_spam_61_cycles", 32'(cy), 32'd61);
        check_small("start_spam");

        sel = 1;
        ws = 0;
        @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (500) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 32'({busy[1], done[1], stb[1], cyc[1], we[1], adr[1], dato[1]}), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        dn = 0;
        act = 0;
        repeat (300) begin
            @(negedge clk);
            dn += int'(done[1]);
            act += int'(busy[1] | stb[1]);
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        chk("abort_stays_idle", 32'(act), 32'd0);
        run(1, 0, 1'b0, "after_abort", cy, na);
        chk("after_abort_7117_cycles", 32'(cy), 32'd7117);

        chk("stb_equals_cyc", 32'(stbcyc_bad), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
